// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: word-addressed, byte-masked data-memory request bus.
//   mem_addr  12-bit word index       req     request, held until valid
//   wr_en     write enable            mask    byte-lane enables
//   w_data    lane-replicated data    r_data  read word from memory
//   valid     one-cycle response from memory
// master = load/store unit, slave = memory.
interface lsu_mem_port_if;
  logic [11:0] mem_addr;
  logic        req;
  logic        wr_en;
  logic [3:0]  mask;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        valid;

  modport master (
    output mem_addr, req, wr_en, mask, w_data,
    input  r_data, valid
  );

  modport slave (
    input  mem_addr, req, wr_en, mask, w_data,
    output r_data, valid
  );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store initiator. Takes one command at a time from
// execute, turns byte-granular LB/LH/LW/LBU/LHU/SB/SH/SW into a word-indexed,
// byte-masked memory request, holds it until the memory answers, and returns
// extended load data or an error.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, is_store, funct3     command strobe and kind (sampled in IDLE)
//   addr, store_data            byte address ([13:2] = word index), store value
//   busy, done, err, load_data  status and result back to the pipeline
//   mem                         memory request bus (master side)
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           load_data,
  lsu_mem_port_if.master        mem
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [11:0]   mem_addr_q, mem_addr_d;
  logic          req_q, req_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   w_data_q, w_data_d;
  // Latched command fields needed to extract the load result on `valid`.
  logic          st_q, st_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;

  // Address bits above the 16 KiB window are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:14];

  // Decode of the incoming command.
  logic        legal, aligned;
  logic [3:0]  mask_new;
  logic [31:0] w_data_new;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    legal      = is_store ? (funct3 inside {3'd0, 3'd1, 3'd2})
                          : (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    aligned    = 1'b1;
    mask_new   = 4'hF;
    w_data_new = store_data;
    case (funct3[1:0])
      2'd0: begin
        mask_new   = 4'b0001 << addr[1:0];
        w_data_new = {4{store_data[7:0]}};
      end
      2'd1: begin
        aligned    = ~addr[0];
        mask_new   = addr[1] ? 4'b1100 : 4'b0011;
        w_data_new = {2{store_data[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by width/sign.
  logic [31:0] lane;
  logic [31:0] ext_data;

  always_comb begin
    lane = mem.r_data >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    ext_data = {{24{lane[7]}},  lane[7:0]};
      3'd1:    ext_data = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ext_data = {24'd0, lane[7:0]};
      3'd5:    ext_data = {16'd0, lane[15:0]};
      default: ext_data = mem.r_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    load_data_d = load_data_q;
    mem_addr_d  = mem_addr_q;
    req_d       = req_q;
    wr_en_d     = wr_en_q;
    mask_d      = mask_q;
    w_data_d    = w_data_q;
    st_d        = st_q;
    f3_d        = f3_q;
    off_d       = off_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        err_d  = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          st_d   = is_store;
          f3_d   = funct3;
          off_d  = addr[1:0];
          if (legal && aligned) begin
            mem_addr_d = addr[13:2];
            req_d      = 1'b1;
            wr_en_d    = is_store;
            mask_d     = mask_new;
            w_data_d   = w_data_new;
            state_d    = S_ACCESS;
          end else begin
            // Rejected before touching memory: report straight away.
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // A response on the same edge the counter expires still counts.
        if (mem.valid) begin
          if (!st_q) load_data_d = ext_data;
          req_d   = 1'b0;
          wr_en_d = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RESP;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          req_d   = 1'b0;
          wr_en_d = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        wr_en_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
      mem_addr_q  <= '0;
      req_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      mask_q      <= '0;
      w_data_q    <= '0;
      st_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      mem_addr_q  <= mem_addr_d;
      req_q       <= req_d;
      wr_en_q     <= wr_en_d;
      mask_q      <= mask_d;
      w_data_q    <= w_data_d;
      st_q        <= st_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign load_data    = load_data_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.req      = req_q;
  assign mem.wr_en    = wr_en_q;
  assign mem.mask     = mask_q;
  assign mem.w_data   = w_data_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: self-checking bench for lsu_mem_port. A behavioural memory
// answers requests after a programmable latency (or never); a byte-array
// reference model predicts masks, write data, load results and error cases.
module tb_lsu_mem_port;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done, err;
  logic [31:0] load_data;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- memory (bus side) ----------------
  logic [31:0] mem_words [4096];
  int          mem_lat = 0;
  bit          mem_mute = 1'b0;
  int          mcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid  <= 1'b0;
      bus.r_data <= 32'd0;
      mcnt       <= 0;
    end else if (bus.req && !bus.valid && !mem_mute) begin
      if (mcnt == mem_lat) begin
        bus.valid  <= 1'b1;
        bus.r_data <= mem_words[bus.mem_addr];
        mcnt       <= 0;
        if (bus.wr_en)
          for (int i = 0; i < 4; i++)
            if (bus.mask[i]) mem_words[bus.mem_addr][8*i +: 8] <= bus.w_data[8*i +: 8];
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      bus.valid  <= 1'b0;
      bus.r_data <= $urandom;
      mcnt       <= 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  model_bytes [16384];
  logic [31:0] exp_ld = 32'd0;

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (st && f3 > 3'd2) return 1'b1;
    if (!st && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    return (int'(a[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = m_size(f3);
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (m_size(f3))
      1:       return 32'(d[7:0]) * 32'h0101_0101;
      2:       return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int sz, idx;
    logic [31:0] v;
    sz  = m_size(f3);
    idx = int'(a[13:0]);
    v   = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(model_bytes[idx + i]) << (8 * i));
    if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[13:0]);
    for (int i = 0; i < m_size(f3); i++) model_bytes[idx + i] = d[8*i +: 8];
  endtask

  // ---------------- stimulus driver (observes, does not judge) ----------------
  typedef struct {
    logic        req0, wr_en0, done0;
    logic [3:0]  mask0;
    logic [31:0] w_data0;
    logic [11:0] mem_addr0;
    int          lat;
    int          req_cycles;
    bit          seen;
    logic        err;
    logic [31:0] load_data;
    logic        busy_done;
    logic        done_after, busy_after;
    longint      t_acc;
  } obs_t;

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output obs_t o);
    int n;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
    @(posedge clk);
    o.t_acc = longint'($time);
    #1;
    start       = 1'b0;
    o.req0      = bus.req;
    o.wr_en0    = bus.wr_en;
    o.mask0     = bus.mask;
    o.w_data0   = bus.w_data;
    o.mem_addr0 = bus.mem_addr;
    o.done0     = done;
    o.req_cycles = int'(bus.req);
    n = 0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      o.req_cycles += int'(bus.req);
    end
    o.seen       = done;
    o.lat        = n;
    o.err        = err;
    o.load_data  = load_data;
    o.busy_done  = busy;
    @(posedge clk); #1;
    o.done_after = done;
    o.busy_after = busy;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++; if ({busy, done, err, load_data, bus.mem_addr, bus.req, bus.wr_en, bus.mask, bus.w_data} !== '0) begin failures++; $display("FAIL reset_outputs got busy=%b done=%b err=%b ld=%h addr=%h req=%b we=%b mask=%h wd=%h required all zero", busy, done, err, load_data, bus.mem_addr, bus.req, bus.wr_en, bus.mask, bus.w_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done, bus.req} !== 3'b000) begin failures++; $display("FAIL reset_idle got busy=%b done=%b req=%b required 000", busy, done, bus.req); end
  endtask

  task automatic test_word();
    obs_t o;
    issue(1'b1, 3'd2, 32'h0000_0008, 32'hDEAD_BEEF, o);
    m_store(3'd2, 32'h8, 32'hDEAD_BEEF);
    checks++; if (o.mem_addr0 !== 12'd2) begin failures++; $display("FAIL sw_mem_addr got=%h required=%h", o.mem_addr0, 12'd2); end
    checks++; if (o.mask0 !== 4'hF || o.wr_en0 !== 1'b1 || o.req0 !== 1'b1) begin failures++; $display("FAIL sw_bus got mask=%h we=%b req=%b required F 1 1", o.mask0, o.wr_en0, o.req0); end
    checks++; if (o.lat !== 2 || o.err !== 1'b0) begin failures++; $display("FAIL sw_latency got lat=%0d err=%b required 2 0", o.lat, o.err); end
    issue(1'b0, 3'd2, 32'h0000_0008, 32'h0, o);
    exp_ld = 32'hDEAD_BEEF;
    checks++; if (o.load_data !== 32'hDEAD_BEEF || o.wr_en0 !== 1'b0) begin failures++; $display("FAIL lw_data got=%h we=%b required DEADBEEF 0", o.load_data, o.wr_en0); end
    checks++; if (o.lat !== 2 || o.err !== 1'b0) begin failures++; $display("FAIL lw_latency got lat=%0d err=%b required 2 0", o.lat, o.err); end
    checks++; if (o.done_after !== 1'b0 || o.busy_after !== 1'b0 || o.busy_done !== 1'b1) begin failures++; $display("FAIL done_pulse got after=%b busy_after=%b busy_done=%b required 0 0 1", o.done_after, o.busy_after, o.busy_done); end
  endtask

  task automatic test_byte();
    obs_t o;
    issue(1'b1, 3'd0, 32'h5, 32'h0000_0080, o);
    m_store(3'd0, 32'h5, 32'h80);
    checks++; if (o.mask0 !== 4'b0010 || o.w_data0 !== 32'h8080_8080) begin failures++; $display("FAIL sb_bus got mask=%b wd=%h required 0010 80808080", o.mask0, o.w_data0); end
    issue(1'b0, 3'd0, 32'h5, 32'h0, o);
    checks++; if (o.load_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h required=FFFFFF80", o.load_data); end
    issue(1'b0, 3'd4, 32'h5, 32'h0, o);
    exp_ld = 32'h0000_0080;
    checks++; if (o.load_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h required=00000080", o.load_data); end
  endtask

  task automatic test_half();
    obs_t o;
    issue(1'b1, 3'd1, 32'h6, 32'h1234_ABCD, o);
    m_store(3'd1, 32'h6, 32'h1234_ABCD);
    checks++; if (o.mask0 !== 4'b1100 || o.w_data0 !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_bus got mask=%b wd=%h required 1100 ABCDABCD", o.mask0, o.w_data0); end
    issue(1'b0, 3'd1, 32'h6, 32'h0, o);
    checks++; if (o.load_data !== 32'hFFFF_ABCD) begin failures++; $display("FAIL lh_data got=%h required=FFFFABCD", o.load_data); end
    issue(1'b0, 3'd5, 32'h6, 32'h0, o);
    exp_ld = 32'h0000_ABCD;
    checks++; if (o.load_data !== 32'h0000_ABCD) begin failures++; $display("FAIL lhu_data got=%h required=0000ABCD", o.load_data); end
  endtask

  task automatic test_errors();
    obs_t o;
    bit          st_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3_t [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [31:0] a_t  [4] = '{32'h2, 32'h3, 32'h8, 32'h8};
    for (int i = 0; i < 4; i++) begin
      issue(st_t[i], f3_t[i], a_t[i], 32'h5555_5555, o);
      checks++; if (o.req_cycles !== 0 || o.done0 !== 1'b1 || o.err !== 1'b1 || o.lat !== 0) begin failures++; $display("FAIL err_case%0d got req_cycles=%0d done0=%b err=%b lat=%0d required 0 1 1 0", i, o.req_cycles, o.done0, o.err, o.lat); end
      checks++; if (o.load_data !== exp_ld || o.busy_after !== 1'b0) begin failures++; $display("FAIL err_hold%0d got ld=%h busy_after=%b required %h 0", i, o.load_data, o.busy_after, exp_ld); end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    mem_mute = 1'b1;
    issue(1'b0, 3'd2, 32'h8, 32'h0, o);
    mem_mute = 1'b0;
    checks++; if (o.req_cycles !== int'(TIMEOUT) || o.lat !== int'(TIMEOUT) || o.err !== 1'b1) begin failures++; $display("FAIL timeout got req_cycles=%0d lat=%0d err=%b required %0d %0d 1", o.req_cycles, o.lat, o.err, TIMEOUT, TIMEOUT); end
    checks++; if (o.load_data !== exp_ld) begin failures++; $display("FAIL timeout_hold got=%h required=%h", o.load_data, exp_ld); end
    // Response lands on the very edge the counter expires: success.
    mem_lat = int'(TIMEOUT) - 2;
    issue(1'b0, 3'd2, 32'h8, 32'h0, o);
    exp_ld = m_load(3'd2, 32'h8);
    checks++; if (o.err !== 1'b0 || o.lat !== int'(TIMEOUT) || o.load_data !== exp_ld) begin failures++; $display("FAIL valid_wins got err=%b lat=%0d ld=%h required 0 %0d %h", o.err, o.lat, o.load_data, TIMEOUT, exp_ld); end
    // One cycle later is too late; the stray valid arrives during RESP.
    mem_lat = int'(TIMEOUT) - 1;
    issue(1'b0, 3'd4, 32'h5, 32'h0, o);
    mem_lat = 0;
    checks++; if (o.err !== 1'b1 || o.req_cycles !== int'(TIMEOUT) || o.load_data !== exp_ld) begin failures++; $display("FAIL late_valid got err=%b req_cycles=%0d ld=%h required 1 %0d %h", o.err, o.req_cycles, o.load_data, TIMEOUT, exp_ld); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int   done_seen;
    mem_mute = 1'b1;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h8;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL async_reset got req=%b busy=%b required 0 0", bus.req, busy); end
    done_seen = 0;
    repeat (2) begin @(posedge clk); #1; done_seen += int'(done); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_mute = 1'b0;
    exp_ld = 32'd0;
    repeat (3) begin @(posedge clk); #1; done_seen += int'(done); end
    checks++; if (done_seen !== 0 || load_data !== 32'd0) begin failures++; $display("FAIL no_done_after_reset got done_cycles=%0d ld=%h required 0 0", done_seen, load_data); end
    issue(1'b0, 3'd2, 32'h8, 32'h0, o);
    exp_ld = m_load(3'd2, 32'h8);
    checks++; if (o.err !== 1'b0 || o.lat !== 2 || o.load_data !== exp_ld) begin failures++; $display("FAIL lw_after_reset got err=%b lat=%0d ld=%h required 0 2 %h", o.err, o.lat, o.load_data, exp_ld); end
    // Hold start (as an illegal store) while busy: must be ignored, not queued.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h8;
    @(posedge clk); #1;
    is_store = 1'b1; funct3 = 3'd4; addr = 32'h3;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (done !== 1'b1 || err !== 1'b0 || load_data !== exp_ld) begin failures++; $display("FAIL start_while_busy got done=%b err=%b ld=%h required 1 0 %h", done, err, load_data, exp_ld); end
    done_seen = 0;
    repeat (3) begin @(posedge clk); #1; done_seen += int'(done) + int'(busy); end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL not_queued got busy_or_done_cycles=%0d required 0", done_seen); end
  endtask

  task automatic test_back_to_back();
    obs_t   o;
    longint t_prev;
    issue(1'b1, 3'd2, 32'h40, 32'h0BAD_F00D, o);
    m_store(3'd2, 32'h40, 32'h0BAD_F00D);
    t_prev = o.t_acc;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 3'd2, 32'h40, 32'h0, o);
      exp_ld = 32'h0BAD_F00D;
      checks++; if (o.t_acc - t_prev !== 64'sd40 || o.load_data !== exp_ld) begin failures++; $display("FAIL b2b%0d got period=%0d ld=%h required 40 %h", i, o.t_acc - t_prev, o.load_data, exp_ld); end
      t_prev = o.t_acc;
    end
  endtask

  task automatic test_random();
    obs_t        o;
    bit          st, e;
    logic [2:0]  f3;
    logic [31:0] a, d, hi, exp_l;
    int          bad;
    for (int i = 0; i < 40; i++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      hi  = $urandom;
      a   = (hi & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      d   = $urandom;
      mem_lat = $urandom_range(0, 3);
      e   = m_err(st, f3, a);
      exp_l = (!e && !st) ? m_load(f3, a) : exp_ld;
      issue(st, f3, a, d, o);
      bad = 0;
      if (!o.seen) bad |= 1;
      if (o.err !== e) bad |= 2;
      if (e && (o.req_cycles !== 0 || o.lat !== 0)) bad |= 4;
      if (!e && (o.req0 !== 1'b1 || o.wr_en0 !== st || o.mask0 !== m_mask(f3, a) || o.mem_addr0 !== a[13:2])) bad |= 8;
      if (!e && st && o.w_data0 !== m_wdata(f3, d)) bad |= 16;
      if (!e && (o.lat !== 2 + mem_lat || o.req_cycles !== 2 + mem_lat)) bad |= 32;
      if (o.load_data !== exp_l) bad |= 64;
      if (o.done_after !== 1'b0 || o.busy_after !== 1'b0) bad |= 128;
      checks++; if (bad != 0) begin failures++; $display("FAIL rand%0d st=%b f3=%0d a=%h code=%0d got err=%b lat=%0d mask=%h wd=%h ld=%h required err=%b mask=%h wd=%h ld=%h", i, st, f3, a, bad, o.err, o.lat, o.mask0, o.w_data0, o.load_data, e, m_mask(f3, a), m_wdata(f3, d), exp_l); end
      if (!e && st) m_store(f3, a, d);
      exp_ld = exp_l;
    end
    mem_lat = 0;
  endtask

  initial begin
    logic [31:0] v;
    for (int w = 0; w < 4096; w++) begin
      v = $urandom;
      mem_words[w] = v;
      for (int b = 0; b < 4; b++) model_bytes[4*w + b] = v[8*b +: 8];
    end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
